// File: rtl/ofdm_burst_framer.sv
// Transmit burst framer: buffers one burst of IFFT samples, then streams it out with a
// cyclic prefix on every symbol and zero padding slots in the preamble.
// Output handshake: a sample moves on dout_valid && dout_ready; dout/dout_valid hold while stalled.
module ofdm_burst_framer #(
    parameter int FFT_POINT  = 64,
    parameter int CP_NUM     = 16,
    parameter int SYMBOL_NUM = 8,
    parameter int PREAMB_SYM = 4,
    parameter int SAMPLE_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                wren,
    output logic                in_buff_full,
    output logic [SAMPLE_W-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                burst_active,
    output logic                tx_done
);
    localparam int N_IN      = (PREAMB_SYM + SYMBOL_NUM) * FFT_POINT;
    localparam int SLOTS     = PREAMB_SYM + 2 + SYMBOL_NUM;
    localparam int SYM_LEN   = FFT_POINT + CP_NUM;
    localparam int BURST_LEN = SLOTS * SYM_LEN;
    localparam int CNT_W     = $clog2(N_IN + 1);
    localparam int ADDR_W    = $clog2(N_IN);
    localparam int SLOT_W    = $clog2(SLOTS);
    localparam int J_W       = $clog2(SYM_LEN);
    localparam int OUT_W     = $clog2(BURST_LEN);

    localparam logic [SLOT_W-1:0] PAD0      = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] PAD1      = SLOT_W'(5);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [J_W-1:0]    J_LAST    = J_W'(SYM_LEN - 1);
    localparam logic [J_W-1:0]    J_CP      = J_W'(CP_NUM);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_IN - 1);
    localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(BURST_LEN - 1);

    typedef enum logic {FILL, SEND} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_in;
    logic [SLOT_W-1:0]   slot_q;
    logic [J_W-1:0]      j_q;
    logic                iss_done;
    logic [OUT_W-1:0]    out_cnt;

    logic [SAMPLE_W-1:0] mem [N_IN];
    logic [SAMPLE_W-1:0] ram_q;
    logic [ADDR_W-1:0]   rd_addr, ram_addr;
    logic                ram_we, is_pad, issue, rd_vld, rd_pad;
    int                  sym_idx, rd_addr_i;

    logic [SAMPLE_W-1:0] fifo [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          fifo_cnt;
    logic [2:0]          occ;
    logic                push, pop, last_pop;

    assign in_buff_full = (state_q == SEND);
    assign dout_valid   = (fifo_cnt != 2'd0);
    assign dout         = fifo[rd_ptr];
    assign pop          = dout_valid && dout_ready;
    assign push         = rd_vld;
    assign last_pop     = pop && (out_cnt == OUT_LAST);
    assign ram_we       = (state_q == FILL) && wren;
    assign is_pad       = (slot_q == PAD0) || (slot_q == PAD1);
    assign ram_addr     = ram_we ? cnt_in[ADDR_W-1:0] : rd_addr;

    // A read may only launch if the FIFO can still absorb it when it lands next cycle.
    assign occ   = {1'b0, fifo_cnt} + {2'b0, rd_vld};
    assign issue = (state_q == SEND) && !iss_done && (occ < (3'd2 + {2'b0, pop}));

    always_comb begin
        sym_idx   = 0;
        rd_addr_i = 0;
        if (slot_q < PAD0)      sym_idx = 32'(slot_q);
        else if (slot_q < PAD1) sym_idx = 32'(slot_q) - 1;
        else                    sym_idx = 32'(slot_q) - 2;
        if (j_q < J_CP) rd_addr_i = sym_idx * FFT_POINT + FFT_POINT - CP_NUM + 32'(j_q);
        else            rd_addr_i = sym_idx * FFT_POINT + 32'(j_q) - CP_NUM;
        rd_addr = ADDR_W'(rd_addr_i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (wren && cnt_in == CNT_LAST) state_d = SEND;
            SEND:    if (last_pop) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= din;
        if (issue && !is_pad) ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            cnt_in       <= '0;
            slot_q       <= '0;
            j_q          <= '0;
            iss_done     <= 1'b0;
            out_cnt      <= '0;
            rd_vld       <= 1'b0;
            rd_pad       <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            fifo[0]      <= '0;
            fifo[1]      <= '0;
            burst_active <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_done <= last_pop;
            if (ram_we)        cnt_in <= cnt_in + CNT_W'(1);
            else if (last_pop) cnt_in <= '0;

            rd_vld <= issue;
            rd_pad <= is_pad;
            if (issue) begin
                if (j_q == J_LAST) begin
                    j_q <= '0;
                    if (slot_q == SLOT_LAST) begin
                        slot_q   <= '0;
                        iss_done <= 1'b1;
                    end else begin
                        slot_q <= slot_q + SLOT_W'(1);
                    end
                end else begin
                    j_q <= j_q + J_W'(1);
                end
            end

            if (push) begin
                fifo[wr_ptr] <= rd_pad ? '0 : ram_q;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= last_pop ? '0 : out_cnt + OUT_W'(1);
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

            if (last_pop) begin
                burst_active <= 1'b0;
                iss_done     <= 1'b0;
            end else if (push) begin
                burst_active <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ofdm_burst_framer.sv
// Directed bench for ofdm_burst_framer: fills bursts with known patterns and checks every
// output sample against the burst layout rebuilt from the written data.
module tb_ofdm_burst_framer;
    localparam int N_IN  = 768;
    localparam int BURST = 1120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'd0;
    logic       wren = 1'b0;
    logic       dout_ready = 1'b0;
    logic       in_buff_full, dout_valid, burst_active, tx_done;
    logic [7:0] dout;

    ofdm_burst_framer dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wren(wren),
        .in_buff_full(in_buff_full), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .burst_active(burst_active), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_buf [N_IN];
    logic [7:0] got [BURST];
    int         got_cnt, first_valid_cyc, gaps, early_done;

    function automatic logic [7:0] pat_val(input int n, input int pat);
        int v;
        v = (pat == 0) ? n : n * 5 + 3;
        return v[7:0];
    endfunction

    // Rebuild the burst layout: 14 slots of 80, slots 2/5 are zero, CP copies the symbol tail.
    function automatic logic [7:0] exp_sample(input int k);
        int slot, j, s, addr;
        slot = k / 80;
        j    = k % 80;
        if (slot == 2 || slot == 5) return 8'd0;
        s    = (slot < 2) ? slot : (slot < 5) ? slot - 1 : slot - 2;
        addr = (j < 16) ? s * 64 + 48 + j : s * 64 + j - 16;
        return exp_buf[addr];
    endfunction

    task automatic fill(input int lo, input int hi, input int pat);
        for (int n = lo; n < hi; n++) begin
            @(posedge clk); #1;
            wren = 1'b1;
            din  = pat_val(n, pat);
            exp_buf[n] = pat_val(n, pat);
        end
        @(posedge clk); #1;
        wren = 1'b0;
    endtask

    task automatic drain(input int bp, input bit junk, input int abort_at);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'd0;
        gaps = 0;
        early_done = 0;
        first_valid_cyc = -1;
        while (k < BURST && cyc < 6000 && !(abort_at >= 0 && k == abort_at)) begin
            @(posedge clk); #1;
            dout_ready = (bp == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            wren = junk;
            din  = 8'hAA;
            @(negedge clk);
            cyc++;
            if (tx_done) early_done++;
            if (stalled) begin
                n_vec++;
                if (dout_valid !== 1'b1 || dout !== held) begin
                    n_err++;
                    $display("FAIL stall_hold k=%0d got valid=%b dout=%0d want valid=1 dout=%0d",
                             k, dout_valid, dout, held);
                end
            end
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bp == 0 && first_valid_cyc >= 0 && !dout_valid) gaps++;
            if (dout_valid && dout_ready) begin
                n_vec++;
                if (dout !== exp_sample(k) || burst_active !== 1'b1) begin
                    n_err++;
                    $display("FAIL sample k=%0d got dout=%0d active=%b want dout=%0d active=1",
                             k, dout, burst_active, exp_sample(k));
                end
                got[k] = dout;
                k++;
            end
            stalled = dout_valid && !dout_ready;
            held    = dout;
        end
        got_cnt = k;
        if (cyc >= 6000) begin
            n_err++;
            $display("FAIL drain_timeout got %0d samples want %0d", k, BURST);
        end
    endtask

    task automatic check_burst(input bit gapless);
        n_vec++;
        if (got_cnt !== BURST) begin
            n_err++;
            $display("FAIL burst_len got %0d want %0d", got_cnt, BURST);
        end
        n_vec++;
        if (first_valid_cyc < 1 || first_valid_cyc > 2) begin
            n_err++;
            $display("FAIL first_valid_latency got %0d want 1..2", first_valid_cyc);
        end
        if (gapless) begin
            n_vec++;
            if (gaps != 0) begin
                n_err++;
                $display("FAIL gapless got %0d gaps want 0", gaps);
            end
        end
    endtask

    task automatic check_done();
        @(posedge clk); #1;
        wren = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tx_done !== 1'b1 || burst_active !== 1'b0 || in_buff_full !== 1'b0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL burst_end got done=%b active=%b full=%b valid=%b want 1 0 0 0",
                     tx_done, burst_active, in_buff_full, dout_valid);
        end
        @(negedge clk);
        n_vec++;
        if (tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL tx_done_width got %b want 0", tx_done);
        end
        n_vec++;
        if (early_done != 0) begin
            n_err++;
            $display("FAIL tx_done_early got %0d want 0", early_done);
        end
    endtask

    task automatic check_idle(input string tag);
        n_vec++;
        if (dout !== 8'd0 || dout_valid !== 1'b0 || in_buff_full !== 1'b0 ||
            burst_active !== 1'b0 || tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s got dout=%0d valid=%b full=%b active=%b done=%b want all 0",
                     tag, dout, dout_valid, in_buff_full, burst_active, tx_done);
        end
    endtask

    task automatic test_reset();
        #3;
        check_idle("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_release");
    endtask

    task automatic test_nominal();
        logic [7:0] spot_val [8];
        int         spot_idx [8];
        spot_idx = '{0, 15, 16, 79, 160, 240, 256, 480};
        spot_val = '{8'd48, 8'd63, 8'd0, 8'd63, 8'd0, 8'd176, 8'd128, 8'd48};
        fill(0, N_IN, 0);
        @(negedge clk);
        n_vec++;
        if (in_buff_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_fill got %b want 1", in_buff_full);
        end
        drain(0, 1'b0, -1);
        check_burst(1'b1);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (got[spot_idx[i]] !== spot_val[i]) begin
                n_err++;
                $display("FAIL spot[%0d] got %0d want %0d", spot_idx[i], got[spot_idx[i]], spot_val[i]);
            end
        end
        n_vec++;
        if (got[1119] !== 8'd255) begin
            n_err++;
            $display("FAIL spot[1119] got %0d want 255", got[1119]);
        end
        for (int i = 160; i < 240; i++) begin
            n_vec++;
            if (got[i] !== 8'd0) begin
                n_err++;
                $display("FAIL pad_slot[%0d] got %0d want 0", i, got[i]);
            end
        end
        check_done();
    endtask

    task automatic test_backpressure();
        fill(0, N_IN, 0);
        drain(1, 1'b0, -1);
        check_burst(1'b0);
        check_done();
    endtask

    task automatic test_write_while_full();
        fill(0, N_IN, 0);
        drain(0, 1'b1, -1);
        check_burst(1'b1);
        check_done();
    endtask

    task automatic test_back_to_back();
        fill(0, N_IN, 1);
        drain(0, 1'b0, -1);
        check_burst(1'b1);
        check_done();
    endtask

    task automatic test_reset_mid_burst();
        fill(0, N_IN, 0);
        drain(0, 1'b0, 500);
        n_vec++;
        if (got_cnt !== 500) begin
            n_err++;
            $display("FAIL reach_500 got %0d want 500", got_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_burst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill(0, N_IN, 1);
        drain(0, 1'b0, -1);
        check_burst(1'b1);
        check_done();
    endtask

    task automatic test_partial_fill();
        fill(0, N_IN - 1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (in_buff_full !== 1'b0 || dout_valid !== 1'b0) begin
                n_err++;
                $display("FAIL partial_hold cyc=%0d got full=%b valid=%b want 0 0", i, in_buff_full, dout_valid);
            end
        end
        fill(N_IN - 1, N_IN, 0);
        @(negedge clk);
        n_vec++;
        if (in_buff_full !== 1'b1) begin
            n_err++;
            $display("FAIL partial_last_write got full=%b want 1", in_buff_full);
        end
        drain(0, 1'b0, -1);
        check_burst(1'b1);
        check_done();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_write_while_full();
        test_back_to_back();
        test_reset_mid_burst();
        test_partial_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
